// File: rtl/riscv_ic_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package riscv_ic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } ic_state_t;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag is whatever is left above the byte, offset and index bits.
  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - 2 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/ic_refill_fsm.sv
// Miss/refill sequencer: captures the missing line base, walks the line word by
// word on the memory bus and tells the cache when to write data, tag and valid.
module ic_refill_fsm
  import riscv_ic_pkg::*;
#(
  parameter  int WORDS  = 4,
  parameter  int LB_W   = 28,
  parameter  int ADDR_W = 32,
  localparam int OFF_W  = off_w(WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_i,
  input  logic              flush_i,
  input  logic              mem_valid_i,
  input  logic [LB_W-1:0]   line_base_i,
  output ic_state_t         state_o,
  output logic [LB_W-1:0]   miss_addr_o,
  output logic [OFF_W-1:0]  cnt_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              word_we_o,
  output logic              line_we_o,
  output logic              valid_clr_o
);

  ic_state_t         state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [LB_W-1:0]   miss_addr_q, miss_addr_d;
  logic              flush_pend_q, flush_pend_d;
  logic              last_beat;

  assign last_beat = (cnt_q == OFF_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_addr_q  <= miss_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_addr_d  = miss_addr_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (miss_i) begin
          state_d     = REFILL;
          cnt_d       = '0;
          miss_addr_d = line_base_i;
        end
      end
      REFILL: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_valid_i) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        state_d      = IDLE;
        flush_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush landing in DONE would otherwise be dropped, so it clears directly.
  always_comb begin
    mem_req_o   = (state_q == REFILL);
    mem_addr_o  = {miss_addr_q, cnt_q, 2'b00};
    word_we_o   = (state_q == REFILL) && mem_valid_i;
    line_we_o   = word_we_o && last_beat;
    valid_clr_o = ((state_q == IDLE) && flush_i)
               || (line_we_o && (flush_pend_q || flush_i))
               || ((state_q == DONE) && flush_i);
  end

  assign state_o     = state_q;
  assign miss_addr_o = miss_addr_q;
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hit path in front of a
// word-serial backing memory, stalling fetch while a line is refilled.
module instr_cache
  import riscv_ic_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);
  localparam int LB_W  = TAG_W + IDX_W;

  logic [31:0]      data_q  [LINES][WORDS];
  logic [TAG_W-1:0] tag_q   [LINES];
  logic             valid_q [LINES];

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [1:0]       pc_unused;
  logic             hit, lookup_hit;

  ic_state_t        fsm_state;
  logic [LB_W-1:0]  miss_addr;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [OFF_W-1:0] cnt;
  logic             word_we, line_we, valid_clr;

  assign pc_unused = pc[1:0];
  assign pc_off    = pc[2 +: OFF_W];
  assign pc_idx    = pc[2 + OFF_W +: IDX_W];
  assign pc_tag    = pc[ADDR_W-1 -: TAG_W];
  assign miss_idx  = miss_addr[IDX_W-1:0];
  assign miss_tag  = miss_addr[LB_W-1 -: TAG_W];

  assign hit        = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign lookup_hit = (fsm_state == IDLE) && hit;
  assign stall      = !lookup_hit;
  assign instr      = lookup_hit ? data_q[pc_idx][pc_off] : 32'h0;

  ic_refill_fsm #(
    .WORDS  (WORDS),
    .LB_W   (LB_W),
    .ADDR_W (ADDR_W)
  ) u_refill (
    .clk         (clk),
    .reset       (reset),
    .miss_i      ((fsm_state == IDLE) && !hit),
    .flush_i     (flush),
    .mem_valid_i (mem_valid),
    .line_base_i ({pc_tag, pc_idx}),
    .state_o     (fsm_state),
    .miss_addr_o (miss_addr),
    .cnt_o       (cnt),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .word_we_o   (word_we),
    .line_we_o   (line_we),
    .valid_clr_o (valid_clr)
  );

  // Data and tag carry no reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (word_we) data_q[miss_idx][cnt] <= mem_rdata;
    if (line_we) tag_q[miss_idx] <= miss_tag;
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (reset || valid_clr) begin
        valid_q[gi] <= 1'b0;
      end else if (line_we && (miss_idx == IDX_W'(gi))) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Randomized self-checking bench for instr_cache against a line-level cache model.
module tb_instr_cache;

  localparam int LINES  = 16;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr;
  logic              stall;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];

  instr_cache #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .stall     (stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00100113;
      32'h8:   return 32'h002081B3;
      32'hC:   return 32'h0000006F;
      default: return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch of address a. On a miss, walks the whole refill with the given
  // per-word memory latency and optionally pulses flush at the start of a beat.
  task automatic fetch(input logic [31:0] a, input int lat, input int flush_beat);
    int          idx;
    int unsigned tg;
    logic [31:0] base;
    int          cycles, beats, wt;
    bit          hit, flushed;
    idx  = int'((a >> 4) & 32'hF);
    tg   = a >> 8;
    base = a & ~32'hF;
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    pc = a;
    #1;
    check_eq("lookup_stall", 32'(stall), 32'(!hit));
    if (hit) begin
      check_eq("hit_instr", instr, mem_word(a & ~32'h3));
      check_eq("hit_req", 32'(mem_req), 32'h0);
      mem_valid = $urandom_range(0, 1) == 1;
      mem_rdata = $urandom;
      tick();
      mem_valid = 1'b0;
      $display("fetch pc=%h hit instr=%h", a, instr);
      return;
    end
    check_eq("miss_instr", instr, 32'h0);
    tick();
    cycles  = 1;
    beats   = 0;
    wt      = 0;
    flushed = 1'b0;
    while (beats < WORDS && cycles < 64) begin
      check_eq("refill_stall", 32'(stall), 32'h1);
      check_eq("refill_req", 32'(mem_req), 32'h1);
      check_eq("mem_addr", mem_addr, base + 32'(beats * 4));
      if (beats == flush_beat && wt == 0 && !flushed) begin
        flush   = 1'b1;
        flushed = 1'b1;
      end
      if (wt == lat) begin
        mem_valid = 1'b1;
        mem_rdata = mem_word(base + 32'(beats * 4));
        beats++;
        wt = 0;
      end else begin
        mem_valid = 1'b0;
        wt++;
      end
      tick();
      flush     = 1'b0;
      mem_valid = 1'b0;
      cycles++;
    end
    check_eq("done_stall", 32'(stall), 32'h1);
    check_eq("done_req", 32'(mem_req), 32'h0);
    mem_valid = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_valid = 1'b0;
    cycles++;
    check_eq("miss_penalty", 32'(cycles), 32'(2 + WORDS * (lat + 1)));
    if (flushed) begin
      model_clear();
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    $display("fetch pc=%h miss lat=%0d flush=%0d cycles=%0d", a, lat, flushed, cycles);
  endtask

  task automatic flush_idle(input logic [31:0] a);
    int          idx;
    bit          hit;
    idx = int'((a >> 4) & 32'hF);
    hit = m_valid[idx] && (m_tag[idx] == (a >> 8));
    pc = a;
    #1;
    check_eq("flush_pre_stall", 32'(stall), 32'(!hit));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    $display("flush in idle pc=%h", a);
  endtask

  // Reset lands after two of four refill beats; the half-filled line must not hit.
  task automatic reset_mid(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'hF;
    pc = a;
    #1;
    check_eq("rm_stall", 32'(stall), 32'h1);
    tick();
    for (int b = 0; b < 2; b++) begin
      check_eq("rm_addr", mem_addr, base + 32'(b * 4));
      mem_valid = 1'b1;
      mem_rdata = mem_word(base + 32'(b * 4));
      tick();
    end
    mem_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rm_req", 32'(mem_req), 32'h0);
    check_eq("rm_stall_after", 32'(stall), 32'h1);
    check_eq("rm_addr_after", mem_addr, 32'h0);
    check_eq("rm_instr", instr, 32'h0);
    model_clear();
    $display("reset mid-refill pc=%h", a);
  endtask

  initial begin
    logic [31:0] a;
    int          fb;
    reset     = 1'b1;
    pc        = '0;
    flush     = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_stall", 32'(stall), 32'h1);
    check_eq("rst_req", 32'(mem_req), 32'h0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_instr", instr, 32'h0);

    fetch(32'h0, 0, -1);
    fetch(32'h0, 0, -1);
    fetch(32'h4, 0, -1);
    fetch(32'h8, 0, -1);
    fetch(32'hC, 0, -1);
    fetch(32'h100, 0, -1);
    fetch(32'h104, 0, -1);
    fetch(32'h0, 0, -1);
    fetch(32'h20, 5, -1);
    fetch(32'h2C, 0, -1);
    flush_idle(32'h0);
    fetch(32'h0, 0, -1);
    fetch(32'h40, 1, 2);
    fetch(32'h40, 1, -1);
    fetch(32'h44, 0, -1);
    reset_mid(32'h80);
    fetch(32'h80, 0, -1);
    fetch(32'h8C, 0, -1);

    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      if ($urandom_range(0, 29) == 0) flush_idle(a);
      fetch(a, int'($urandom_range(0, 3)), fb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
